// File: rtl/fp_accel_pkg.sv
// Shared definitions for the fingerprint accelerator: scheduler state encodings
// and the ceiling-division helper used to size word counts.
package fp_accel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD_REF = 2'd1,
    ST_CMP      = 2'd2,
    ST_DONE     = 2'd3
  } sched_state_t;

  // Also sizes the vector concatenator's SUB_VEC_NO, so both sides agree on word counts.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/beat_cntr.sv
// Up-counter with enable, synchronous clear and a terminal-count flag.
// Clear has priority over enable so the wrap back to 0 happens on the terminal beat.
module beat_cntr #(
  parameter int WIDTH    = 5,
  parameter int TERMINAL = 28
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clr,
  output logic tc
);

  logic [WIDTH-1:0] count;

  assign tc = (count == WIDTH'(TERMINAL));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/batch_sched.sv
// Batch scheduler: forwards REF_WORDS reference words, then compare words up to the
// last-flagged one, to the vector concatenator. Pops and data are combinational on i_Read.
//   state       | meaning
//   ST_IDLE     | waiting for i_Start, all outputs quiet
//   ST_LOAD_REF | forwarding reference FIFO words
//   ST_CMP      | forwarding compare FIFO words until i_CmpLast is accepted
//   ST_DONE     | one-cycle o_Done pulse, batch counter increments
module batch_sched
  import fp_accel_pkg::*;
#(
  parameter int BUS_WIDTH       = 128,
  parameter int VECTOR_WIDTH    = 920,
  parameter int REF_VEC_NO      = 4,
  parameter int BATCH_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_Start,
  output logic                       o_Busy,
  output logic                       o_Done,
  input  logic [BUS_WIDTH-1:0]       i_RefData,
  input  logic                       i_RefValid,
  output logic                       o_RefRead,
  input  logic [BUS_WIDTH-1:0]       i_CmpData,
  input  logic                       i_CmpValid,
  input  logic                       i_CmpLast,
  output logic                       o_CmpRead,
  output logic [BUS_WIDTH-1:0]       o_Vector,
  output logic                       o_Valid,
  output logic                       o_Last,
  output logic                       o_Phase,
  input  logic                       i_Read,
  output logic [BATCH_CNT_WIDTH-1:0] o_BatchCnt
);

  localparam int REF_WORDS = ceil_div(REF_VEC_NO * VECTOR_WIDTH, BUS_WIDTH);
  localparam int CNT_W     = (REF_WORDS > 1) ? $clog2(REF_WORDS) : 1;

  sched_state_t state, next_state;
  logic         ref_accept;
  logic         cmp_accept;
  logic         word_tc;

  assign ref_accept = (state == ST_LOAD_REF) && i_RefValid && i_Read;
  assign cmp_accept = (state == ST_CMP) && i_CmpValid && i_Read;

  beat_cntr #(
    .WIDTH    (CNT_W),
    .TERMINAL (REF_WORDS - 1)
  ) u_word_cntr (
    .clk  (clk),
    .rstn (rstn),
    .en   (ref_accept),
    .clr  (ref_accept && word_tc),
    .tc   (word_tc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_BatchCnt <= '0;
    end else if (state == ST_DONE) begin
      o_BatchCnt <= o_BatchCnt + BATCH_CNT_WIDTH'(1);
    end
  end

  always_comb begin
    next_state = state;
    o_Busy     = 1'b0;
    o_Done     = 1'b0;
    o_RefRead  = 1'b0;
    o_CmpRead  = 1'b0;
    o_Vector   = '0;
    o_Valid    = 1'b0;
    o_Last     = 1'b0;
    o_Phase    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_Start) next_state = ST_LOAD_REF;
      end
      ST_LOAD_REF: begin
        o_Busy    = 1'b1;
        o_Vector  = i_RefData;
        o_Valid   = i_RefValid;
        o_RefRead = i_RefValid && i_Read;
        if (ref_accept && word_tc) next_state = ST_CMP;
      end
      ST_CMP: begin
        o_Busy    = 1'b1;
        o_Phase   = 1'b1;
        o_Vector  = i_CmpData;
        o_Valid   = i_CmpValid;
        o_CmpRead = i_CmpValid && i_Read;
        o_Last    = i_CmpValid && i_CmpLast;
        if (cmp_accept && i_CmpLast) next_state = ST_DONE;
      end
      ST_DONE: begin
        o_Busy     = 1'b1;
        o_Done     = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_batch_sched.sv
// Directed bench for batch_sched: reset, full batch, read throttling, early compare-last,
// ignored starts, mid-batch reset and batch counter wrap.
module tb_batch_sched;

  localparam int BW = 128;
  localparam int RW = 29;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start, ref_valid, cmp_valid, cmp_last, rd;
  logic [BW-1:0] ref_data, cmp_data;
  logic          busy, done, ref_read, cmp_read, valid, last, phase;
  logic [BW-1:0] vec;
  logic [7:0]    batch_cnt;
  logic [6:0]    ctl;

  int n_tests = 0;
  int n_fail  = 0;

  // Packed view of the control outputs: {busy, done, valid, last, phase, ref_read, cmp_read}
  assign ctl = {busy, done, valid, last, phase, ref_read, cmp_read};

  always #5 clk = ~clk;

  batch_sched #(
    .BUS_WIDTH       (BW),
    .VECTOR_WIDTH    (920),
    .REF_VEC_NO      (4),
    .BATCH_CNT_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_Start    (start),
    .o_Busy     (busy),
    .o_Done     (done),
    .i_RefData  (ref_data),
    .i_RefValid (ref_valid),
    .o_RefRead  (ref_read),
    .i_CmpData  (cmp_data),
    .i_CmpValid (cmp_valid),
    .i_CmpLast  (cmp_last),
    .o_CmpRead  (cmp_read),
    .o_Vector   (vec),
    .o_Valid    (valid),
    .o_Last     (last),
    .o_Phase    (phase),
    .i_Read     (rd),
    .o_BatchCnt (batch_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    start = 0; ref_valid = 0; cmp_valid = 0; cmp_last = 0; rd = 0;
    ref_data = '0; cmp_data = '0;
  endtask

  // Drives one batch with always-valid FIFOs; returns observations, checks nothing itself.
  task automatic run_batch(output int pops, output bit saw_done, output bit timeout);
    pops = 0; saw_done = 0; timeout = 1;
    start = 1; ref_valid = 1; cmp_valid = 1; rd = 1; cmp_last = 0;
    tick();
    start = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (phase === 1'b1) begin
        timeout = 0;
        break;
      end
      if (ref_read === 1'b1) pops++;
      tick();
    end
    cmp_last = 1;
    #1;
    tick();
    cmp_last = 0;
    #1;
    saw_done = (done === 1'b1);
    tick();
    ref_valid = 0; cmp_valid = 0; rd = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    start = 1; ref_valid = 1; cmp_valid = 1; cmp_last = 1; rd = 1;
    ref_data = {BW{1'b1}}; cmp_data = {BW{1'b1}};
    #3;
    n_tests++;
    if (ctl !== 7'b0000000) begin
      n_fail++; $display("FAIL reset_ctl got %b exp %b", ctl, 7'b0000000);
    end
    n_tests++;
    if (vec !== '0) begin
      n_fail++; $display("FAIL reset_vec got %h exp 0", vec);
    end
    n_tests++;
    if (batch_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_bcnt got %0d exp 0", batch_cnt);
    end
    tick(); tick();
    n_tests++;
    if (ctl !== 7'b0000000) begin
      n_fail++; $display("FAIL reset_hold_ctl got %b exp %b", ctl, 7'b0000000);
    end
    idle_inputs();
    rstn = 1;
  endtask

  task automatic test_basic(inout int exp_bcnt);
    start = 1; ref_valid = 1; cmp_valid = 1; rd = 1;
    #1;
    n_tests++;
    if (ctl !== 7'b0000000 || vec !== '0) begin
      n_fail++; $display("FAIL basic_idle got ctl %b vec %h exp 0000000/0", ctl, vec);
    end
    tick();
    start = 0;
    for (int k = 0; k < RW; k++) begin
      ref_data = {32'hA5A5_0000 + k, 32'h1111_0000 + k, 32'h2222_0000 + k, 32'h3333_0000 + k};
      #1;
      n_tests++;
      if (ctl !== 7'b1010010 || vec !== ref_data) begin
        n_fail++; $display("FAIL basic_ref k=%0d got ctl %b vec %h exp 1010010 vec %h", k, ctl, vec, ref_data);
      end
      tick();
    end
    for (int j = 0; j < 4; j++) begin
      cmp_data = {32'hC0DE_0000 + j, 96'h0};
      cmp_last = (j == 3);
      #1;
      n_tests++;
      if (ctl !== (j == 3 ? 7'b1011101 : 7'b1010101) || vec !== cmp_data) begin
        n_fail++; $display("FAIL basic_cmp j=%0d got ctl %b vec %h exp last=%0d vec %h", j, ctl, vec, j == 3, cmp_data);
      end
      tick();
    end
    cmp_last = 0;
    #1;
    n_tests++;
    if (ctl !== 7'b1100000 || vec !== '0) begin
      n_fail++; $display("FAIL basic_done got ctl %b vec %h exp 1100000/0", ctl, vec);
    end
    tick();
    exp_bcnt++;
    n_tests++;
    if (ctl !== 7'b0000000 || batch_cnt !== 8'(exp_bcnt)) begin
      n_fail++; $display("FAIL basic_end got ctl %b bcnt %0d exp 0000000 bcnt %0d", ctl, batch_cnt, exp_bcnt);
    end
    idle_inputs();
  endtask

  task automatic test_read_toggle(inout int exp_bcnt);
    int pops = 0;
    bit reached = 0;
    start = 1; ref_valid = 1; cmp_valid = 1; rd = 1;
    tick();
    start = 0;
    for (int c = 0; c < 200; c++) begin
      rd = (c % 2 == 0);
      #1;
      if (phase === 1'b1) begin
        reached = 1;
        break;
      end
      n_tests++;
      if (ref_read !== rd || cmp_read !== 1'b0) begin
        n_fail++; $display("FAIL toggle_pop c=%0d got rr %b cr %b exp rr %b cr 0", c, ref_read, cmp_read, rd);
      end
      if (ref_read === 1'b1) pops++;
      tick();
    end
    n_tests++;
    if (!reached || pops != RW) begin
      n_fail++; $display("FAIL toggle_count got reached %0d pops %0d exp 1 pops %0d", reached, pops, RW);
    end
    rd = 1; cmp_last = 1;
    #1;
    tick();
    cmp_last = 0;
    #1;
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL toggle_done got %b exp 1", done);
    end
    tick();
    exp_bcnt++;
    n_tests++;
    if (batch_cnt !== 8'(exp_bcnt)) begin
      n_fail++; $display("FAIL toggle_bcnt got %0d exp %0d", batch_cnt, exp_bcnt);
    end
    idle_inputs();
  endtask

  task automatic test_cmp_last_early(inout int exp_bcnt);
    start = 1; ref_valid = 1; cmp_valid = 1; cmp_last = 1; rd = 1;
    tick();
    start = 0;
    for (int k = 0; k < RW; k++) begin
      #1;
      n_tests++;
      if (ctl !== 7'b1010010) begin
        n_fail++; $display("FAIL early_ref k=%0d got ctl %b exp 1010010", k, ctl);
      end
      tick();
    end
    cmp_last = 0; rd = 0;
    #1;
    n_tests++;
    if (ctl !== 7'b1010100) begin
      n_fail++; $display("FAIL early_stall got ctl %b exp 1010100", ctl);
    end
    tick();
    rd = 1;
    #1;
    n_tests++;
    if (ctl !== 7'b1010101) begin
      n_fail++; $display("FAIL early_word got ctl %b exp 1010101", ctl);
    end
    tick();
    cmp_last = 1;
    #1;
    n_tests++;
    if (ctl !== 7'b1011101) begin
      n_fail++; $display("FAIL early_last got ctl %b exp 1011101", ctl);
    end
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (ctl !== 7'b1100000) begin
      n_fail++; $display("FAIL early_done got ctl %b exp 1100000", ctl);
    end
    tick();
    exp_bcnt++;
    n_tests++;
    if (busy !== 1'b0 || batch_cnt !== 8'(exp_bcnt)) begin
      n_fail++; $display("FAIL early_end got busy %b bcnt %0d exp 0 bcnt %0d", busy, batch_cnt, exp_bcnt);
    end
  endtask

  task automatic test_start_ignored(inout int exp_bcnt);
    start = 1; ref_valid = 1; cmp_valid = 1; rd = 1;
    tick();
    for (int k = 0; k < RW; k++) begin
      start = (k == 10);
      #1;
      n_tests++;
      if (ctl !== 7'b1010010) begin
        n_fail++; $display("FAIL ign_ref k=%0d got ctl %b exp 1010010", k, ctl);
      end
      tick();
    end
    start = 0; cmp_last = 1;
    #1;
    n_tests++;
    if (ctl !== 7'b1011101) begin
      n_fail++; $display("FAIL ign_cmp got ctl %b exp 1011101", ctl);
    end
    tick();
    cmp_last = 0; start = 1;
    #1;
    n_tests++;
    if (ctl !== 7'b1100000) begin
      n_fail++; $display("FAIL ign_done got ctl %b exp 1100000", ctl);
    end
    tick();
    start = 0;
    #1;
    n_tests++;
    if (ctl !== 7'b0000000) begin
      n_fail++; $display("FAIL ign_idle1 got ctl %b exp 0000000", ctl);
    end
    tick();
    #1;
    exp_bcnt++;
    n_tests++;
    if (ctl !== 7'b0000000 || batch_cnt !== 8'(exp_bcnt)) begin
      n_fail++; $display("FAIL ign_idle2 got ctl %b bcnt %0d exp 0000000 bcnt %0d", ctl, batch_cnt, exp_bcnt);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid(inout int exp_bcnt);
    int  pops;
    bit  saw_done, timeout;
    start = 1; ref_valid = 1; cmp_valid = 1; rd = 1;
    tick();
    start = 0;
    for (int k = 0; k < 15; k++) tick();
    rstn = 0;
    #1;
    n_tests++;
    if (ctl !== 7'b0000000 || vec !== '0 || batch_cnt !== 8'd0) begin
      n_fail++; $display("FAIL midrst_now got ctl %b vec %h bcnt %0d exp 0000000/0/0", ctl, vec, batch_cnt);
    end
    tick();
    #1;
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_hold got done %b busy %b exp 0 0", done, busy);
    end
    idle_inputs();
    rstn = 1;
    exp_bcnt = 0;
    run_batch(pops, saw_done, timeout);
    exp_bcnt++;
    n_tests++;
    if (timeout || pops != RW || !saw_done || batch_cnt !== 8'(exp_bcnt)) begin
      n_fail++; $display("FAIL midrst_next got to %0d pops %0d done %0d bcnt %0d exp 0 %0d 1 %0d",
                         timeout, pops, saw_done, batch_cnt, RW, exp_bcnt);
    end
  endtask

  task automatic test_wrap(inout int exp_bcnt);
    int  pops, bad;
    bit  saw_done, timeout;
    bad = 0;
    rstn = 0;
    tick();
    rstn = 1;
    exp_bcnt = 0;
    for (int b = 0; b < 255; b++) begin
      run_batch(pops, saw_done, timeout);
      if (timeout || pops != RW || !saw_done) bad++;
    end
    n_tests++;
    if (batch_cnt !== 8'd255) begin
      n_fail++; $display("FAIL wrap_255 got %0d exp 255", batch_cnt);
    end
    run_batch(pops, saw_done, timeout);
    if (timeout || pops != RW || !saw_done) bad++;
    n_tests++;
    if (batch_cnt !== 8'd0) begin
      n_fail++; $display("FAIL wrap_0 got %0d exp 0", batch_cnt);
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL wrap_batches got %0d bad batches exp 0", bad);
    end
  endtask

  initial begin
    int exp_bcnt;
    exp_bcnt = 0;
    test_reset();
    test_basic(exp_bcnt);
    test_read_toggle(exp_bcnt);
    test_cmp_last_early(exp_bcnt);
    test_start_ignored(exp_bcnt);
    test_reset_mid(exp_bcnt);
    test_wrap(exp_bcnt);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/batch_sched.md
BATCH_SCHED -- requirements
Module: batch_sched

Interface
REQ-001 The module SHALL have a parameter BUS_WIDTH, default 128, giving the data word width in bits.
REQ-002 The module SHALL have a parameter VECTOR_WIDTH, default 920, giving the fingerprint vector width in bits.
REQ-003 The module SHALL have a parameter REF_VEC_NO, default 4, giving the number of reference vectors per batch.
REQ-004 The module SHALL have a parameter BATCH_CNT_WIDTH, default 8, giving the batch counter width.
REQ-005 The module SHALL derive localparam REF_WORDS = ceil(REF_VEC_NO*VECTOR_WIDTH/BUS_WIDTH), which is 29 at the defaults.
REQ-006 Ports SHALL be, in this order:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- i_Start  in  1  request to start one batch.
- o_Busy  out  1  a batch is in progress.
- o_Done  out  1  one-cycle pulse at batch end.
- i_RefData  in  BUS_WIDTH  reference FIFO word.
- i_RefValid  in  1  reference FIFO not empty.
- o_RefRead  out  1  pop the reference FIFO.
- i_CmpData  in  BUS_WIDTH  compare FIFO word.
- i_CmpValid  in  1  compare FIFO not empty.
- i_CmpLast  in  1  last word of the compare stream.
- o_CmpRead  out  1  pop the compare FIFO.
- o_Vector  out  BUS_WIDTH  word sent to the vector concatenator.
- o_Valid  out  1  o_Vector is valid.
- o_Last  out  1  last word of the batch.
- o_Phase  out  1  0 = reference load, 1 = compare.
- i_Read  in  1  the concatenator accepts a word this cycle.
- o_BatchCnt  out  BATCH_CNT_WIDTH  number of completed batches.

Function
REQ-007 The FSM SHALL have the states IDLE, LOAD_REF, CMP and DONE, held in a registered state variable.
REQ-008 IDLE SHALL move to LOAD_REF when i_Start=1; otherwise it SHALL stay in IDLE.
REQ-009 A word SHALL be accepted on a cycle where o_Valid=1 and i_Read=1; no counter or state SHALL advance without acceptance.
REQ-010 In LOAD_REF:
- o_Vector SHALL equal i_RefData.
- o_Valid SHALL equal i_RefValid.
- o_RefRead SHALL equal i_RefValid AND i_Read.
- o_CmpRead SHALL be 0.
REQ-011 The word counter SHALL count accepted reference words from 0; on acceptance with count=REF_WORDS-1, the FSM SHALL go to CMP and the counter SHALL clear to 0.
REQ-012 In CMP:
- o_Vector SHALL equal i_CmpData.
- o_Valid SHALL equal i_CmpValid.
- o_CmpRead SHALL equal i_CmpValid AND i_Read.
- o_Last SHALL equal i_CmpValid AND i_CmpLast.
- o_RefRead SHALL be 0.
REQ-013 Acceptance of a word with i_CmpLast=1 SHALL move the FSM to DONE.
REQ-014 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-015 In DONE:
- o_Done SHALL be 1.
- o_BatchCnt SHALL increment, wrapping modulo 2^BATCH_CNT_WIDTH.
REQ-016 o_Busy SHALL be 1 in LOAD_REF, CMP and DONE.
REQ-017 o_Phase SHALL be 1 only in CMP.
REQ-018 In IDLE and DONE, o_Valid, o_Last, o_RefRead and o_CmpRead SHALL all be 0, and o_Vector SHALL be 0.
REQ-019 i_Start while o_Busy=1 SHALL be ignored and SHALL NOT be queued; this includes i_Start during DONE.
REQ-020 Compare data present during LOAD_REF, and reference data present during CMP, SHALL NOT be popped.
REQ-021 i_CmpLast during LOAD_REF SHALL have no effect.
REQ-022 All outputs SHALL be combinational from the state register and inputs, with zero-cycle latency from i_Read to the pop outputs.
REQ-023 The only registers SHALL be the state, the word counter (width $clog2(REF_WORDS)) and o_BatchCnt.

Reset
REQ-024 rstn=0 SHALL asynchronously force state=IDLE, word counter=0 and o_BatchCnt=0.
REQ-025 As a result of reset, all outputs SHALL take their IDLE values.
REQ-026 A reset mid-batch SHALL abandon the batch without asserting o_Done.
REQ-027 Reset release SHALL be synchronous to clk; the first i_Start SHALL be sampled on the first rising edge with rstn=1.

Structure
REQ-028 Package fp_accel_pkg SHALL hold:
- the FSM state encodings;
- the ceil-division constant function used for REF_WORDS, shared with the vector concatenator's SUB_VEC_NO.
REQ-029 One sub-module, beat_cntr, SHALL be used: a parameterised up-counter with enable, synchronous clear and terminal-count flag, instantiated for the word counter.

Verification
REQ-030 Reset, then i_Start=1 with both FIFOs always valid and i_Read=1 -> 29 reference words forwarded with o_Phase=0, then compare words with o_Phase=1 until i_CmpLast, then o_Done=1 for one cycle and o_BatchCnt=1.
REQ-031 During LOAD_REF, toggle i_Read 1/0 every cycle -> still exactly 29 o_RefRead pulses, then the switch to CMP; o_RefRead never 1 while i_Read=0.
REQ-032 i_CmpValid=1 with i_CmpLast=1 during LOAD_REF -> o_CmpRead stays 0 and no DONE until the compare last word is accepted in CMP.
REQ-033 Pulse i_Start at word 10 of LOAD_REF and again during DONE -> both ignored; a single batch completes and o_BatchCnt increments by 1.
REQ-034 Assert rstn=0 at reference word 15 -> state, outputs and o_BatchCnt return to reset values immediately, with no o_Done.
REQ-035 Run 256 batches with BATCH_CNT_WIDTH=8 -> o_BatchCnt wraps from 255 to 0.
